sample_packer: RTL and testbench



---
 rtl/sample_packer.sv | 161 ++++++++++++++++
 tb/tb_sample_packer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_packer.sv
// rtl/sample_packer.sv - packs per-channel I/Q samples into fixed-width words grouped into packets
module sample_packer #(
    parameter int NCH       = 3,
    parameter int QBITS     = 2,
    parameter int RAW_BITS  = 8,
    parameter int WORD      = 16,
    parameter int PKT_WORDS = 720
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [NCH*QBITS-1:0]     q_i,
    input  logic [NCH*QBITS-1:0]     q_q,
    input  logic [NCH*RAW_BITS-1:0]  raw_i,
    input  logic [NCH*RAW_BITS-1:0]  raw_q,
    input  logic                     enable,
    input  logic [1:0]               mode,
    input  logic [2:0]               chan_sel,
    output logic [WORD-1:0]          out_data,
    output logic                     out_en,
    output logic                     out_end,
    output logic [15:0]              packet_count,
    output logic [1:0]               active_mode
);

    localparam int S0  = 2 * NCH * QBITS;
    localparam int S1  = 2 * RAW_BITS;
    localparam int AW  = 2 * WORD;
    localparam int CW  = $clog2(AW) + 1;
    localparam int WCW = $clog2(PKT_WORDS);

    localparam logic [1:0]     MODE_RAW  = 2'd1;
    localparam logic [3:0]     NCH_L     = 4'(NCH);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);

    generate
        if (S0 > WORD || S1 > WORD || NCH < 1 || NCH > 8 || PKT_WORDS < 2) begin : g_param_check
            $error("sample_packer: illegal parameter combination");
        end
    endgenerate

    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WCW-1:0]  wcnt_q, wcnt_d;
    logic [15:0]     pkt_q, pkt_d;
    logic [1:0]      mode_q, mode_d;
    logic [2:0]      chan_q, chan_d;
    logic [WORD-1:0] out_data_q, out_data_d;
    logic            out_en_q, out_en_d;
    logic            out_end_q, out_end_d;

    logic [2:0]          sel_chan;
    logic [WORD-1:0]     field_pk;
    logic [WORD-1:0]     field;
    logic [RAW_BITS-1:0] raw_i_sel;
    logic [RAW_BITS-1:0] raw_q_sel;
    logic [CW-1:0]       s_len;
    logic [AW-1:0]       sum_acc;
    logic [CW-1:0]       sum_cnt;
    logic [CW-1:0]       rem_cnt;
    logic [AW-1:0]       rem_acc;
    logic [WORD-1:0]     word;
    logic                emit;

    assign sel_chan = ({1'b0, chan_sel} < NCH_L) ? chan_sel : 3'd0;

    always_comb begin
        field_pk = '0;
        for (int n = 0; n < NCH; n++) begin
            field_pk = (field_pk << QBITS) | WORD'(q_i[n*QBITS +: QBITS]);
            field_pk = (field_pk << QBITS) | WORD'(q_q[n*QBITS +: QBITS]);
        end
    end

    assign raw_i_sel = raw_i[chan_q*RAW_BITS +: RAW_BITS];
    assign raw_q_sel = raw_q[chan_q*RAW_BITS +: RAW_BITS];
    assign field     = (mode_q == MODE_RAW) ? WORD'({raw_i_sel, raw_q_sel}) : field_pk;
    assign s_len     = (mode_q == MODE_RAW) ? CW'(S1) : CW'(S0);

    // Residual bits sit right-aligned in acc_q; the oldest bit is at position cnt_q-1.
    assign sum_acc = (acc_q << s_len) | AW'(field);
    assign sum_cnt = cnt_q + s_len;
    assign emit    = (sum_cnt >= CW'(WORD));
    assign rem_cnt = sum_cnt - CW'(WORD);
    assign word    = WORD'(sum_acc >> rem_cnt);
    assign rem_acc = sum_acc & ~({AW{1'b1}} << rem_cnt);

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        wcnt_d     = wcnt_q;
        pkt_d      = pkt_q;
        mode_d     = mode_q;
        chan_d     = chan_q;
        out_data_d = '0;
        out_en_d   = 1'b0;
        out_end_d  = 1'b0;
        if (!enable) begin
            acc_d  = '0;
            cnt_d  = '0;
            wcnt_d = '0;
            mode_d = mode;
            chan_d = sel_chan;
        end else if (in_valid && !mode_q[1]) begin
            if (emit) begin
                out_en_d   = 1'b1;
                out_data_d = word;
                acc_d      = rem_acc;
                cnt_d      = rem_cnt;
                if (wcnt_q == LAST_WORD) begin
                    wcnt_d    = '0;
                    out_end_d = 1'b1;
                    pkt_d     = pkt_q + 16'd1;
                    mode_d    = mode;
                    chan_d    = sel_chan;
                    // A straddling sample only carries over if the stream format is unchanged.
                    if (mode != mode_q || sel_chan != chan_q) begin
                        acc_d = '0;
                        cnt_d = '0;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end else begin
                acc_d = sum_acc;
                cnt_d = sum_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            wcnt_q     <= '0;
            pkt_q      <= '0;
            mode_q     <= '0;
            chan_q     <= '0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            out_end_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            wcnt_q     <= wcnt_d;
            pkt_q      <= pkt_d;
            mode_q     <= mode_d;
            chan_q     <= chan_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            out_end_q  <= out_end_d;
        end
    end

    assign out_data     = out_data_q;
    assign out_en       = out_en_q;
    assign out_end      = out_end_q;
    assign packet_count = pkt_q;
    assign active_mode  = mode_q;

endmodule

// File: tb/tb_sample_packer.sv
// tb/tb_sample_packer.sv - self-checking bench for sample_packer with a bit-queue scoreboard model
module tb_sample_packer;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [5:0]  q_i, q_q;
    logic [23:0] raw_i, raw_q;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  chan_sel;
    logic [15:0] out_data;
    logic        out_en;
    logic        out_end;
    logic [15:0] packet_count;
    logic [1:0]  active_mode;

    sample_packer dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .q_i(q_i), .q_q(q_q), .raw_i(raw_i), .raw_q(raw_q),
        .enable(enable), .mode(mode), .chan_sel(chan_sel),
        .out_data(out_data), .out_en(out_en), .out_end(out_end),
        .packet_count(packet_count), .active_mode(active_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic [15:0] w;
        bit          last;
        logic [15:0] pkts;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  chan;
        logic [5:0]  qi, qq;
        logic [23:0] ri, rq;
        int          nsamp;
        bit          alt;
        int          nwords;
        logic [15:0] first;
    } vec_t;

    exp_t        sb[$];
    logic [15:0] seen[$];
    bit          bq[$];
    int          m_wcnt;
    logic [1:0]  m_mode;
    logic [2:0]  m_chan;
    logic [15:0] m_pkts;

    logic        t_en, t_valid;
    logic [1:0]  t_mode;
    logic [2:0]  t_chan;
    logic [5:0]  t_qi, t_qq;
    logic [23:0] t_ri, t_rq;

    function automatic logic [2:0] effc(input logic [2:0] c);
        return (c < 3'd3) ? c : 3'd0;
    endfunction

    task automatic model_reset();
        bq.delete();
        sb.delete();
        m_wcnt = 0;
        m_mode = 2'd0;
        m_chan = 3'd0;
        m_pkts = 16'd0;
    endtask

    task automatic model_step();
        logic [15:0] w;
        bit          last;
        if (!t_en) begin
            bq.delete();
            m_wcnt = 0;
            m_mode = t_mode;
            m_chan = effc(t_chan);
        end else if (t_valid && m_mode < 2'd2) begin
            if (m_mode == 2'd0) begin
                for (int n = 0; n < 3; n++) begin
                    for (int b = 1; b >= 0; b--) bq.push_back(t_qi[n*2+b]);
                    for (int b = 1; b >= 0; b--) bq.push_back(t_qq[n*2+b]);
                end
            end else begin
                for (int b = 7; b >= 0; b--) bq.push_back(t_ri[m_chan*8+b]);
                for (int b = 7; b >= 0; b--) bq.push_back(t_rq[m_chan*8+b]);
            end
            if (bq.size() >= 16) begin
                w = '0;
                for (int k = 0; k < 16; k++) w = {w[14:0], bq.pop_front()};
                last = (m_wcnt == 719);
                if (last) begin
                    m_pkts = m_pkts + 16'd1;
                    m_wcnt = 0;
                    if (t_mode != m_mode || effc(t_chan) != m_chan) bq.delete();
                    m_mode = t_mode;
                    m_chan = effc(t_chan);
                end else begin
                    m_wcnt++;
                end
                sb.push_back('{w, last, m_pkts, cyc + 1});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        enable   = t_en;
        in_valid = t_valid;
        mode     = t_mode;
        chan_sel = t_chan;
        q_i      = t_qi;
        q_q      = t_qq;
        raw_i    = t_ri;
        raw_q    = t_rq;
        model_step();
    endtask

    task automatic drain();
        t_valid = 1'b0;
        repeat (3) step();
        chk(sb.size() == 0, "scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (out_en) begin
                seen.push_back(out_data);
                if (sb.size() == 0) begin
                    chk(1'b0, "unexpected_word", {16'd0, out_data}, 0);
                end else begin
                    e = sb.pop_front();
                    chk(out_data == e.w, "word_data", {16'd0, out_data}, {16'd0, e.w});
                    chk(out_end == e.last, "word_end", {31'd0, out_end}, {31'd0, e.last});
                    chk(cyc == e.cyc, "word_timing", cyc, e.cyc);
                    if (e.last) chk(packet_count == e.pkts, "pkt_at_end", {16'd0, packet_count}, {16'd0, e.pkts});
                end
            end else begin
                chk(out_data == 16'd0, "idle_data_zero", {16'd0, out_data}, 0);
                chk(out_end == 1'b0, "idle_no_end", {31'd0, out_end}, 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
        $fatal(1, "timeout");
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd0, 3'd0, 6'b011101, 6'b010010, 24'h0, 24'h0, 8, 1'b0, 6, 16'h6C56};
        vecs[1] = '{2'd0, 3'd0, 6'b011101, 6'b010010, 24'h0, 24'h0, 8, 1'b1, 6, 16'h6C56};
        vecs[2] = '{2'd1, 3'd1, 6'b0, 6'b0, 24'h001200, 24'h003400, 4, 1'b0, 4, 16'h1234};
        vecs[3] = '{2'd1, 3'd5, 6'b0, 6'b0, 24'h0000AB, 24'h0000CD, 4, 1'b1, 4, 16'hABCD};
        vecs[4] = '{2'd0, 3'd0, 6'b111111, 6'b111111, 24'h0, 24'h0, 8, 1'b0, 6, 16'hFFFF};
        vecs[5] = '{2'd0, 3'd2, 6'b100111, 6'b010010, 24'h0, 24'h0, 8, 1'b0, 6, 16'hE49E};
        vecs[6] = '{2'd2, 3'd0, 6'b011101, 6'b010010, 24'h0, 24'h0, 8, 1'b0, 0, 16'h0000};

        t_en = 1'b0; t_valid = 1'b0; t_mode = 2'd0; t_chan = 3'd0;
        t_qi = '0; t_qq = '0; t_ri = '0; t_rq = '0;
        enable = 1'b0; in_valid = 1'b0; mode = 2'd0; chan_sel = 3'd0;
        q_i = '0; q_q = '0; raw_i = '0; raw_q = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk(out_en == 1'b0, "reset_out_en", {31'd0, out_en}, 0);
        chk(out_data == 16'd0, "reset_out_data", {16'd0, out_data}, 0);
        chk(out_end == 1'b0, "reset_out_end", {31'd0, out_end}, 0);
        chk(packet_count == 16'd0, "reset_pkt", {16'd0, packet_count}, 0);
        chk(active_mode == 2'd0, "reset_mode", {30'd0, active_mode}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        for (int v = 0; v < 7; v++) begin
            t_en = 1'b0; t_valid = 1'b0;
            t_mode = vecs[v].mode; t_chan = vecs[v].chan;
            t_qi = vecs[v].qi; t_qq = vecs[v].qq; t_ri = vecs[v].ri; t_rq = vecs[v].rq;
            step();
            seen.delete();
            t_en = 1'b1;
            for (int i = 0; i < vecs[v].nsamp; i++) begin
                t_valid = 1'b1;
                step();
                if (vecs[v].alt) begin
                    t_valid = 1'b0;
                    step();
                end
            end
            drain();
            chk(seen.size() == vecs[v].nwords, "vec_word_count", seen.size(), vecs[v].nwords);
            if (vecs[v].nwords > 0 && seen.size() > 0)
                chk(seen[0] == vecs[v].first, "vec_first_word", {16'd0, seen[0]}, {16'd0, vecs[v].first});
            chk(active_mode == vecs[v].mode, "vec_active_mode", {30'd0, active_mode}, {30'd0, vecs[v].mode});
        end

        // Two full packets; a raw-mode request arrives mid second packet and must wait for out_end.
        t_en = 1'b0; t_valid = 1'b0; t_mode = 2'd0; t_chan = 3'd0;
        t_qi = 6'b011101; t_qq = 6'b010010; t_ri = 24'h001200; t_rq = 24'h003400;
        step();
        seen.delete();
        t_en = 1'b1;
        for (int i = 0; i < 1925; i++) begin
            if (i == 960 + 134) begin
                t_mode = 2'd1;
                t_chan = 3'd1;
            end
            t_valid = 1'b1;
            step();
        end
        drain();
        chk(seen.size() == 1445, "long_word_count", seen.size(), 1445);
        if (seen.size() == 1445) begin
            chk(seen[720] == 16'h6C56, "next_pkt_first", {16'd0, seen[720]}, 16'h6C56);
            chk(seen[1439] == 16'h56C5, "pre_switch_word", {16'd0, seen[1439]}, 16'h56C5);
            chk(seen[1444] == 16'h1234, "raw_word", {16'd0, seen[1444]}, 16'h1234);
        end
        chk(packet_count == 16'd2, "long_pkt_count", {16'd0, packet_count}, 2);
        chk(active_mode == 2'd1, "long_active_mode", {30'd0, active_mode}, 1);

        // Asynchronous reset while a word is on the output.
        t_valid = 1'b1;
        repeat (3) step();
        t_valid = 1'b0;
        step();
        #2 reset_n = 1'b0;
        #1;
        chk(out_en == 1'b0, "async_out_en", {31'd0, out_en}, 0);
        chk(out_data == 16'd0, "async_out_data", {16'd0, out_data}, 0);
        chk(packet_count == 16'd0, "async_pkt", {16'd0, packet_count}, 0);
        chk(active_mode == 2'd0, "async_mode", {30'd0, active_mode}, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        t_mode = 2'd0; t_chan = 3'd0;
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            t_valid = 1'b1;
            step();
        end
        drain();
        if (seen.size() > 0) chk(seen[0] == 16'h6C56, "post_reset_first", {16'd0, seen[0]}, 16'h6C56);
        chk(seen.size() == 6, "post_reset_count", seen.size(), 6);

        // Enable dropped mid-packet with samples still offered during the gap.
        seen.delete();
        for (int i = 0; i < 400; i++) begin
            t_valid = 1'b1;
            step();
        end
        t_en = 1'b0;
        repeat (5) step();
        t_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        drain();
        chk(seen.size() == 306, "gap_word_count", seen.size(), 306);
        if (seen.size() == 306) chk(seen[300] == 16'h6C56, "restart_first", {16'd0, seen[300]}, 16'h6C56);
        chk(packet_count == 16'd0, "gap_pkt_held", {16'd0, packet_count}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
